// File: rtl/tug_of_war_referee_if.sv
// Player-input / display-output bundle for the Tug of War referee.
interface tug_of_war_referee_if #(
   parameter int unsigned NUM_LIGHTS = 9,
   parameter int unsigned SCORE_MAX  = 7
);
   localparam int unsigned SW = $clog2(SCORE_MAX + 1);

   logic                  l_press;
   logic                  r_press;
   logic [NUM_LIGHTS-1:0] lights;
   logic [SW-1:0]         l_score;
   logic [SW-1:0]         r_score;
   logic [1:0]            winner;
   logic                  game_over;

   // Button side: drives the player levels, observes the display outputs.
   modport master (
      output l_press, r_press,
      input  lights, l_score, r_score, winner, game_over
   );

   // Referee side.
   modport slave (
      input  l_press, r_press,
      output lights, l_score, r_score, winner, game_over
   );
endinterface

// File: rtl/tug_of_war_referee.sv
// Tug of War game controller: tap detection, light movement, scoring, win hold.
module tug_of_war_referee #(
   parameter int unsigned NUM_LIGHTS  = 9,
   parameter int unsigned SCORE_MAX   = 7,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   tug_of_war_referee_if.slave        bus
);
   localparam int unsigned CENTER = (NUM_LIGHTS - 1) / 2;
   localparam int unsigned SW     = $clog2(SCORE_MAX + 1);
   localparam int unsigned PW     = $clog2(NUM_LIGHTS);
   localparam int unsigned CW     = $clog2(HOLD_CYCLES + 1);

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b01;
   localparam logic [1:0] WIN_RIGHT = 2'b10;

   typedef enum logic [1:0] {
      ST_PLAY       = 2'd0,
      ST_WIN_HOLD   = 2'd1,
      ST_MATCH_OVER = 2'd2
   } state_t;

   state_t                state_q;
   logic [PW-1:0]         pos_q;
   logic [CW-1:0]         cnt_q;
   logic [NUM_LIGHTS-1:0] lights_q;
   logic [SW-1:0]         l_score_q;
   logic [SW-1:0]         r_score_q;
   logic [1:0]            winner_q;
   logic                  game_over_q;
   logic                  l_prev_q;
   logic                  r_prev_q;
   logic                  l_tap_c;
   logic                  r_tap_c;

   // Rising-edge detection on the already-synchronized button levels.
   assign l_tap_c = bus.l_press & ~l_prev_q;
   assign r_tap_c = bus.r_press & ~r_prev_q;

   assign bus.lights    = lights_q;
   assign bus.l_score   = l_score_q;
   assign bus.r_score   = r_score_q;
   assign bus.winner    = winner_q;
   assign bus.game_over = game_over_q;

   // Game FSM with all outputs registered; taps act on the edge they are sampled.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_PLAY;
         pos_q       <= PW'(CENTER);
         cnt_q       <= '0;
         lights_q    <= NUM_LIGHTS'(1) << CENTER;
         l_score_q   <= '0;
         r_score_q   <= '0;
         winner_q    <= WIN_NONE;
         game_over_q <= 1'b0;
         // Loading the live level means a button held through reset is not a tap.
         l_prev_q    <= bus.l_press;
         r_prev_q    <= bus.r_press;
      end else begin
         l_prev_q <= bus.l_press;
         r_prev_q <= bus.r_press;
         case (state_q)
            ST_PLAY: begin
               if (l_tap_c && !r_tap_c) begin
                  if (pos_q == PW'(NUM_LIGHTS - 1)) begin
                     l_score_q <= (l_score_q == SW'(SCORE_MAX)) ? l_score_q
                                                                : l_score_q + SW'(1);
                     winner_q  <= WIN_LEFT;
                     lights_q  <= '0;
                     cnt_q     <= '0;
                     state_q   <= ST_WIN_HOLD;
                  end else begin
                     pos_q    <= pos_q + PW'(1);
                     lights_q <= NUM_LIGHTS'(1) << (pos_q + PW'(1));
                  end
               end else if (r_tap_c && !l_tap_c) begin
                  if (pos_q == '0) begin
                     r_score_q <= (r_score_q == SW'(SCORE_MAX)) ? r_score_q
                                                                : r_score_q + SW'(1);
                     winner_q  <= WIN_RIGHT;
                     lights_q  <= '0;
                     cnt_q     <= '0;
                     state_q   <= ST_WIN_HOLD;
                  end else begin
                     pos_q    <= pos_q - PW'(1);
                     lights_q <= NUM_LIGHTS'(1) << (pos_q - PW'(1));
                  end
               end
            end
            ST_WIN_HOLD: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                  if (((winner_q == WIN_LEFT)  && (l_score_q == SW'(SCORE_MAX))) ||
                      ((winner_q == WIN_RIGHT) && (r_score_q == SW'(SCORE_MAX)))) begin
                     state_q     <= ST_MATCH_OVER;
                     game_over_q <= 1'b1;
                  end else begin
                     state_q  <= ST_PLAY;
                     pos_q    <= PW'(CENTER);
                     lights_q <= NUM_LIGHTS'(1) << CENTER;
                     winner_q <= WIN_NONE;
                  end
               end
            end
            ST_MATCH_OVER: begin
               // Terminal until reset.
               lights_q <= '0;
            end
            default: begin
               state_q <= ST_PLAY;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tug_of_war_referee.sv
// Directed self-checking bench for tug_of_war_referee (NUM_LIGHTS=9, SCORE_MAX=7, HOLD_CYCLES=4).
module tb_tug_of_war_referee;
   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   tug_of_war_referee_if #(.NUM_LIGHTS(9), .SCORE_MAX(7)) bus ();

   tug_of_war_referee #(.NUM_LIGHTS(9), .SCORE_MAX(7), .HOLD_CYCLES(4)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Raise the requested buttons for exactly one edge, then drop them.
   task automatic tap(input logic l, input logic r);
      bus.l_press = l;
      bus.r_press = r;
      step(1);
      bus.l_press = 1'b0;
      bus.r_press = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_lights"}, 32'(bus.lights), 32'h010);
      chk({tag, "_lsc"},    32'(bus.l_score), 32'd0);
      chk({tag, "_rsc"},    32'(bus.r_score), 32'd0);
      chk({tag, "_win"},    32'(bus.winner), 32'd0);
      chk({tag, "_go"},     32'(bus.game_over), 32'd0);
   endtask

   initial begin
      logic [31:0] walk [4];
      walk[0] = 32'h020; walk[1] = 32'h040; walk[2] = 32'h080; walk[3] = 32'h100;
      n_tests = 0;
      n_fail  = 0;

      // Reset with left button held; holding it afterwards must not move the light.
      reset       = 1'b1;
      bus.l_press = 1'b1;
      bus.r_press = 1'b0;
      step(1);
      chk_reset_vals("rst");
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("held_after_rst", 32'(bus.lights), 32'h010);
      end
      bus.l_press = 1'b0;
      step(1);

      // Walk left with single taps, fifth tap wins.
      for (int i = 0; i < 4; i++) begin
         tap(1'b1, 1'b0);
         chk("walk_left", 32'(bus.lights), walk[i]);
         step(1);
      end
      tap(1'b1, 1'b0);
      chk("lwin_lights", 32'(bus.lights), 32'h0);
      chk("lwin_winner", 32'(bus.winner), 32'd1);
      chk("lwin_score",  32'(bus.l_score), 32'd1);
      step(3);
      chk("hold3_lights", 32'(bus.lights), 32'h0);
      chk("hold3_winner", 32'(bus.winner), 32'd1);
      step(1);
      chk("hold4_lights", 32'(bus.lights), 32'h010);
      chk("hold4_winner", 32'(bus.winner), 32'd0);

      // Simultaneous taps cancel.
      do_reset();
      step(1);
      for (int i = 0; i < 3; i++) begin
         tap(1'b1, 1'b1);
         chk("cancel_lights", 32'(bus.lights), 32'h010);
         step(1);
      end
      chk("cancel_lsc", 32'(bus.l_score), 32'd0);
      chk("cancel_rsc", 32'(bus.r_score), 32'd0);

      // A long press is a single step.
      bus.l_press = 1'b1;
      step(1);
      chk("long_first", 32'(bus.lights), 32'h020);
      step(9);
      chk("long_end", 32'(bus.lights), 32'h020);
      bus.l_press = 1'b0;
      step(1);

      // Right player takes the whole match.
      do_reset();
      step(1);
      for (int rnd = 1; rnd <= 7; rnd++) begin
         for (int i = 0; i < 4; i++) begin
            tap(1'b0, 1'b1);
            step(1);
         end
         chk("rwalk_end", 32'(bus.lights), 32'h001);
         tap(1'b0, 1'b1);
         chk("rwin_winner", 32'(bus.winner), 32'd2);
         chk("rwin_score",  32'(bus.r_score), 32'(rnd));
         chk("rwin_lights", 32'(bus.lights), 32'h0);
         step(3);
         chk("rhold3_go", 32'(bus.game_over), 32'd0);
         step(1);
         if (rnd < 7) begin
            chk("rnext_lights", 32'(bus.lights), 32'h010);
            chk("rnext_winner", 32'(bus.winner), 32'd0);
         end
      end
      chk("match_go",     32'(bus.game_over), 32'd1);
      chk("match_winner", 32'(bus.winner), 32'd2);
      chk("match_lights", 32'(bus.lights), 32'h0);
      chk("match_rsc",    32'(bus.r_score), 32'd7);
      step(1);
      tap(1'b1, 1'b0);
      step(1);
      tap(1'b0, 1'b1);
      step(1);
      chk("frozen_lights", 32'(bus.lights), 32'h0);
      chk("frozen_rsc",    32'(bus.r_score), 32'd7);
      chk("frozen_lsc",    32'(bus.l_score), 32'd0);
      chk("frozen_go",     32'(bus.game_over), 32'd1);
      do_reset();
      chk_reset_vals("post_match_rst");

      // Reset in the middle of a win hold.
      step(1);
      for (int i = 0; i < 4; i++) begin
         tap(1'b1, 1'b0);
         step(1);
      end
      tap(1'b1, 1'b0);
      chk("mid_win", 32'(bus.winner), 32'd1);
      step(2);
      do_reset();
      chk_reset_vals("hold_rst");
      step(1);
      tap(1'b1, 1'b0);
      chk("hold_rst_play", 32'(bus.lights), 32'h020);
      step(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
